// File: rtl/shift_register_nx.sv
// shift_register_nx: parametrised universal shift register.
// Supports hold, logical shift, parallel load, rotate and arithmetic shift,
// each moving STEP bits per command. A self-timed serialise mode streams a
// loaded word out of the LSB chunk, STEP bits per cycle, and reports
// busy/done status.
module shift_register_nx #(
  parameter int N    = 8,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [STEP-1:0] sin,
  input  logic [N-1:0]    data,
  output logic [N-1:0]    q_reg,
  output logic [STEP-1:0] sout,
  output logic            busy,
  output logic            done
);

  localparam int BEATS = N / STEP;
  localparam int CW    = $clog2(BEATS + 1);

  localparam logic [CW-1:0] LP_BEATS = CW'(BEATS);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_LOAD = 3'd3,
    OP_ROR  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ASR  = 3'd6,
    OP_SER  = 3'd7
  } op_e;

  logic [N-1:0]  r_q;
  logic [N-1:0]  w_q_next;
  logic [N-1:0]  w_shr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_done;
  logic          w_done_next;
  logic          w_busy;

  // A run is in progress exactly while beats remain to be sent.
  assign w_busy = (r_cnt != '0);

  // Shift right with serial fill; shared by op 1 and every serialise beat.
  assign w_shr = {sin, r_q[N-1:STEP]};

  // Next-state selection: an active run owns the register, otherwise the
  // accepted command decides.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_q_next    = r_q;
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    if (w_busy) begin
      w_q_next    = w_shr;
      w_cnt_next  = r_cnt - LP_ONE;
      w_done_next = (r_cnt == LP_ONE);
    end else if (en) begin
      case (op_e'(op))
        OP_HOLD: w_q_next = r_q;
        OP_SHR:  w_q_next = w_shr;
        OP_SHL:  w_q_next = {r_q[N-STEP-1:0], sin};
        OP_LOAD: w_q_next = data;
        OP_ROR:  w_q_next = {r_q[STEP-1:0], r_q[N-1:STEP]};
        OP_ROL:  w_q_next = {r_q[N-STEP-1:0], r_q[N-1:N-STEP]};
        OP_ASR:  w_q_next = {{STEP{r_q[N-1]}}, r_q[N-1:STEP]};
        OP_SER: begin
          w_q_next   = data;
          w_cnt_next = LP_BEATS;
        end
        default: w_q_next = r_q;
      endcase
    end
  end

  // State register with asynchronous clear that also aborts any run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      r_q    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  assign q_reg = r_q;
  assign sout  = r_q[STEP-1:0];
  assign busy  = w_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_shift_register_nx.sv
// tb_shift_register_nx: drives three configurations of shift_register_nx
// (8x1, 16x4, 8x4) with directed and random commands and compares them
// against an arithmetic reference model.
module tb_shift_register_nx;

  localparam int NI = 3;
  localparam int NN [NI] = '{8, 16, 8};
  localparam int SS [NI] = '{1, 4, 4};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NI-1:0] t_en;
  logic [2:0]    t_op   [NI];
  logic [31:0]   t_sin  [NI];
  logic [31:0]   t_data [NI];

  logic [7:0]    q0;
  logic [15:0]   q1;
  logic [7:0]    q2;
  logic [0:0]    sout0;
  logic [3:0]    sout1;
  logic [3:0]    sout2;
  logic [NI-1:0] busy_v;
  logic [NI-1:0] done_v;

  shift_register_nx #(.N(8), .STEP(1)) u_n8s1 (
    .clk(clk), .reset_n(reset_n), .en(t_en[0]), .op(t_op[0]),
    .sin(t_sin[0][0:0]), .data(t_data[0][7:0]),
    .q_reg(q0), .sout(sout0), .busy(busy_v[0]), .done(done_v[0])
  );

  shift_register_nx #(.N(16), .STEP(4)) u_n16s4 (
    .clk(clk), .reset_n(reset_n), .en(t_en[1]), .op(t_op[1]),
    .sin(t_sin[1][3:0]), .data(t_data[1][15:0]),
    .q_reg(q1), .sout(sout1), .busy(busy_v[1]), .done(done_v[1])
  );

  shift_register_nx #(.N(8), .STEP(4)) u_n8s4 (
    .clk(clk), .reset_n(reset_n), .en(t_en[2]), .op(t_op[2]),
    .sin(t_sin[2][3:0]), .data(t_data[2][7:0]),
    .q_reg(q2), .sout(sout2), .busy(busy_v[2]), .done(done_v[2])
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: register value, beats still to send, done flag.
  logic [31:0] m_q    [NI];
  int          m_rem  [NI];
  logic        m_done [NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_q(input int i);
    case (i)
      0:       return {24'd0, q0};
      1:       return {16'd0, q1};
      default: return {24'd0, q2};
    endcase
  endfunction

  function automatic logic [31:0] obs_sout(input int i);
    case (i)
      0:       return {31'd0, sout0};
      1:       return {28'd0, sout1};
      default: return {28'd0, sout2};
    endcase
  endfunction

  // Result of one command on an n-bit value moving s bits, in plain arithmetic.
  function automatic logic [31:0] apply_op(input int n, input int s, input int op,
                                           input logic [31:0] q, input logic [31:0] sin,
                                           input logic [31:0] data);
    logic [31:0] mask  = (32'd1 << n) - 32'd1;
    logic [31:0] smask = (32'd1 << s) - 32'd1;
    logic [31:0] top   = mask & ~(mask >> s);
    case (op)
      1:       return (q >> s) | ((sin & smask) << (n - s));
      2:       return ((q << s) | (sin & smask)) & mask;
      3, 7:    return data & mask;
      4:       return (q >> s) | ((q & smask) << (n - s));
      5:       return ((q << s) & mask) | (q >> (n - s));
      6:       return (q >> s) | (q[n-1] ? top : 32'd0);
      default: return q;
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NI; i++) begin
      m_q[i]    = '0;
      m_rem[i]  = 0;
      m_done[i] = 1'b0;
    end
  endtask

  // Advance the model with the inputs present before the edge, then move to
  // 1 time unit after the rising edge where outputs are stable.
  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        m_q[i] = '0; m_rem[i] = 0; m_done[i] = 1'b0;
      end else if (m_rem[i] > 0) begin
        m_q[i]    = apply_op(NN[i], SS[i], 1, m_q[i], t_sin[i], t_data[i]);
        m_rem[i]  = m_rem[i] - 1;
        m_done[i] = (m_rem[i] == 0);
      end else begin
        m_done[i] = 1'b0;
        if (t_en[i]) begin
          m_q[i] = apply_op(NN[i], SS[i], int'(t_op[i]), m_q[i], t_sin[i], t_data[i]);
          if (t_op[i] == 3'd7) m_rem[i] = NN[i] / SS[i];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int i);
    logic [31:0] smask = (32'd1 << SS[i]) - 32'd1;
    check($sformatf("q[%0d]", i),    obs_q(i),            m_q[i]);
    check($sformatf("sout[%0d]", i), obs_sout(i),         m_q[i] & smask);
    check($sformatf("busy[%0d]", i), {31'd0, busy_v[i]},  {31'd0, m_rem[i] != 0});
    check($sformatf("done[%0d]", i), {31'd0, done_v[i]},  {31'd0, m_done[i]});
  endtask

  task automatic cmd(input int i, input logic [2:0] op, input logic [31:0] sin,
                     input logic [31:0] data);
    t_en[i] = 1'b1; t_op[i] = op; t_sin[i] = sin; t_data[i] = data;
    tick();
    t_en[i] = 1'b0;
  endtask

  initial begin
    int          beats;
    bit          saw_done;
    logic [31:0] d;

    reset_n = 1'b0;
    t_en    = '0;
    for (int i = 0; i < NI; i++) begin
      t_op[i] = '0; t_sin[i] = '0; t_data[i] = '0;
    end
    reset_model();

    // Reset dominates a pending load.
    t_en[0] = 1'b1; t_op[0] = 3'd3; t_data[0] = 32'hFF;
    tick();
    check("rst_q",    {24'd0, q0},          32'h00);
    check("rst_busy", {29'd0, busy_v},      32'd0);
    check("rst_done", {29'd0, done_v},      32'd0);
    #2 reset_n = 1'b1;
    tick();
    check("rst_release_load", {24'd0, q0}, 32'hFF);
    t_en[0] = 1'b0;

    // Single-bit modes.
    cmd(0, 3'd3, 0, 32'hA5); check("load_a5", {24'd0, q0}, 32'hA5);
    cmd(0, 3'd1, 1, 0);      check("shr",     {24'd0, q0}, 32'hD2);
    check("shr_sout", {31'd0, sout0}, 32'd0);
    cmd(0, 3'd3, 0, 32'hA5); cmd(0, 3'd2, 0, 0);
    check("shl", {24'd0, q0}, 32'h4A);
    cmd(0, 3'd3, 0, 32'hA5); cmd(0, 3'd5, 0, 0);
    check("rol", {24'd0, q0}, 32'h4B);
    cmd(0, 3'd3, 0, 32'h85); cmd(0, 3'd6, 1, 0);
    check("asr", {24'd0, q0}, 32'hC2);
    cmd(0, 3'd3, 0, 32'hA5); cmd(0, 3'd0, 1, 32'h33);
    check("hold", {24'd0, q0}, 32'hA5);
    t_op[0] = 3'd3; t_data[0] = 32'h00; tick();
    check("en_low", {24'd0, q0}, 32'hA5);

    // Four-bit step on a 16-bit register.
    cmd(1, 3'd3, 0, 32'h1234); cmd(1, 3'd4, 0, 0);
    check("ror16", {16'd0, q1}, 32'h4123);
    cmd(1, 3'd3, 0, 32'h1234); cmd(1, 3'd2, 32'hF, 0);
    check("shl16", {16'd0, q1}, 32'h234F);
    cmd(1, 3'd3, 0, 32'h8000); cmd(1, 3'd6, 0, 0);
    check("asr16", {16'd0, q1}, 32'hF800);

    // Serialise 3C in two nibbles, a load attempt during the run is ignored,
    // then a second run is issued in the done cycle.
    cmd(2, 3'd7, 32'hA, 32'h3C);
    check("ser_busy0", {31'd0, busy_v[2]}, 32'd1);
    check("ser_sout0", {28'd0, sout2},     32'hC);
    t_en[2] = 1'b1; t_op[2] = 3'd3; t_data[2] = 32'hFF;
    tick();
    check("ser_busy1", {31'd0, busy_v[2]}, 32'd1);
    check("ser_sout1", {28'd0, sout2},     32'h3);
    check("ser_mid_q", {24'd0, q2},        32'hA3);
    tick();
    check("ser_done",  {31'd0, done_v[2]}, 32'd1);
    check("ser_idle",  {31'd0, busy_v[2]}, 32'd0);
    check("ser_q",     {24'd0, q2},        32'hAA);
    t_op[2] = 3'd7; t_data[2] = 32'h5A; t_sin[2] = 32'h6;
    tick();
    t_en[2] = 1'b0;
    check("b2b_busy0", {31'd0, busy_v[2]}, 32'd1);
    check("b2b_done0", {31'd0, done_v[2]}, 32'd0);
    check("b2b_sout0", {28'd0, sout2},     32'hA);
    tick();
    check("b2b_sout1", {28'd0, sout2},     32'h5);
    tick();
    check("b2b_done",  {31'd0, done_v[2]}, 32'd1);
    check("b2b_q",     {24'd0, q2},        32'h66);
    tick();
    check("done_clears", {31'd0, done_v[2]}, 32'd0);

    // Reset in the third busy cycle of an 8-beat run.
    cmd(0, 3'd7, 1, 32'h96);
    tick(); tick();
    check("mid_busy3", {31'd0, busy_v[0]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    reset_model();
    check("mid_rst_q",    {24'd0, q0},     32'd0);
    check("mid_rst_busy", {29'd0, busy_v}, 32'd0);
    check("mid_rst_done", {29'd0, done_v}, 32'd0);
    tick(); tick();
    check("mid_rst_nodone", {29'd0, done_v}, 32'd0);
    reset_n = 1'b1;
    tick();
    d = $urandom & 32'hFF;
    cmd(0, 3'd7, $urandom, d);
    beats = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 20 && !saw_done; c++) begin
      if (busy_v[0]) begin
        check($sformatf("rerun_chunk%0d", beats), {31'd0, sout0}, (d >> beats) & 32'd1);
        beats++;
      end
      if (done_v[0]) saw_done = 1'b1;
      else tick();
    end
    check("rerun_beats", beats, 32'd8);
    check("rerun_done",  {31'd0, saw_done}, 32'd1);
    check_model(0);

    // Random commands on all three configurations against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++) begin
        t_en[i]   = ($urandom_range(0, 3) != 0);
        t_op[i]   = 3'($urandom_range(0, 7));
        t_sin[i]  = $urandom;
        t_data[i] = $urandom;
      end
      tick();
      for (int i = 0; i < NI; i++) check_model(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_register_nx.md
# shift_register_nx

Parametrised universal shift register. Generalises the plain shift/load register to a configurable width and a configurable shift step, and adds rotate and arithmetic-shift modes. It also has a self-timed serialise mode that streams a loaded word out STEP bits per cycle, with busy/done status. It sits between parallel datapaths and narrow serial links, e.g. as a parallel-to-serial converter or a barrel-free multi-bit shifter stage.

## Interface
- N, default 8: register width in bits; N >= 2.
- STEP, default 1: bits moved per shift; 1 <= STEP < N, and N must be a multiple of STEP.
- Derived: BEATS = N/STEP; CW = clog2(BEATS+1) is the counter width.

- clk, input, 1: single clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset; clears all state immediately.
- en, input, 1: command valid; sampled only when busy = 0.
- op, input, 3: command code (see Operation).
- sin, input, STEP: serial fill bits for shift and serialise modes.
- data, input, N: parallel load word.
- q_reg, output, N: current register contents (registered).
- sout, output, STEP: q_reg[STEP-1:0] (the LSB chunk); combinational from the register.
- busy, output, 1: high while a serialise run is in progress; equals (cnt != 0).
- done, output, 1: registered one-cycle pulse marking the end of a serialise run.

## Operation
- Reset (reset_n = 0):
  - q_reg = 0, cnt = 0, done = 0, therefore sout = 0 and busy = 0.
  - Takes effect asynchronously and overrides any run in progress.
- Idle (busy = 0, en = 0): register holds its value.
- Idle (busy = 0, en = 1): op is applied at the next edge.
  - 0 hold: q unchanged.
  - 1 shift right: q = {sin, q[N-1:STEP]}.
  - 2 shift left: q = {q[N-STEP-1:0], sin}.
  - 3 load: q = data.
  - 4 rotate right: q = {q[STEP-1:0], q[N-1:STEP]}.
  - 5 rotate left: q = {q[N-STEP-1:0], q[N-1:N-STEP]}.
  - 6 arithmetic shift right: q = {STEP copies of q[N-1], q[N-1:STEP]}; sin ignored.
  - 7 serialise: q = data and cnt = BEATS.
- Serialise run (busy = 1):
  - Each edge performs a shift right with sin and decrements cnt.
  - en, op and data are ignored for the whole run; there is no abort other than reset.
  - On the edge where cnt goes from 1 to 0, done is set to 1. done clears on the following edge.
- done is 0 on every other edge.
- In the done cycle busy = 0, so a new command, including another op 7, is accepted that cycle.

## Timing
- Ops 0–6: one-cycle latency; q_reg reflects the result after the accepting edge.
- Op 7 accepted at edge E0:
  - busy is high for exactly BEATS cycles, from after E0 through after edge E0+BEATS-1.
  - Chunk k = data[(k+1)*STEP-1 : k*STEP] is on sout in cycle k after E0, for k = 0..BEATS-1.
  - After edge E0+BEATS: busy = 0, done = 1, and q_reg holds the BEATS sin values shifted in, the last one in the MSB chunk.
  - Back-to-back runs are gap-free except for the done cycle.
- reset_n asserted mid-run: all outputs are 0 immediately. After release, the block is idle and the first edge with en = 1 is a normal accept.

## Test plan
- Reset: hold reset_n = 0 with en = 1, op = 3, data = 8'hFF -> q_reg = 0, busy = 0, done = 0. Release -> next edge loads FF.
- Modes (N = 8, STEP = 1), each starting from a fresh load:
  - load A5 -> A5.
  - shift right, sin = 1 -> D2.
  - shift left, sin = 0 -> 4A.
  - rotate left -> 4B.
  - arithmetic shift right from 85 -> C2.
  - hold -> unchanged.
  - en = 0 with op = 3 -> unchanged.
- Multi-bit step (N = 16, STEP = 4), from 16'h1234:
  - rotate right -> 4123.
  - shift left, sin = F -> 234F.
  - arithmetic shift right from 8000 -> F800.
- Serialise (N = 8, STEP = 4), data = 3C, sin = A:
  - sout is C then 3 in the two busy cycles.
  - Then done = 1 for one cycle and q_reg = AA.
  - op = 3 during busy is ignored.
- Back-to-back: issue op 7 again in the done cycle -> new run starts, busy = 1 on the next cycle, no lost chunk.
- Mid-run reset: N = 8, STEP = 1, assert reset_n low at the third busy cycle -> q_reg, busy and done = 0 immediately, done never pulses. A new op 7 after release completes with BEATS = 8 busy cycles.
